xor_add_pipe: RTL and testbench

Parametrised successor to the 8-bit register/adder/XOR exercise circuit used in the lab and midterm series. It captures an input word, forms a registered constant-offset sum, and delays the input through a configurable-depth delay line. It then combines three registered terms under a selectable mode. Unlike the fixed 8-bit version, it adds:

- a valid-qualified advance (stall) input,
- a fill tracker that drives `out_valid`,
- a clear value on every register, including the adder.

---
 rtl/xor_add_pipe.sv | 78 +++++++
 tb/tb_xor_add_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/xor_add_pipe.sv
// Capture / constant-offset adder / delay-line pipeline whose three registered terms are
// combined under a selectable mode. Valid-qualified advance, fill tracking, synchronous clear.
module xor_add_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned OFFSET    = 17,
  parameter int unsigned CLEAR_VAL = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] cct_input,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cct_output,
  output logic             out_valid
);

  localparam int unsigned      FillW   = $clog2(DEPTH + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);
  localparam logic [WIDTH-1:0] OffW    = WIDTH'(OFFSET);
  localparam logic [WIDTH-1:0] ClearW  = WIDTH'(CLEAR_VAL);

  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] dly_q [DEPTH];
  logic [WIDTH-1:0] dly_d [DEPTH];
  logic [FillW-1:0] fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] tap;

  // Advance values; the clock block only applies them when in_valid is set.
  always_comb begin
    cap_d = cct_input;
    sum_d = cct_input + OffW;
    dly_d[0] = cct_input;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      dly_d[k] = dly_q[k-1];
    end
    fill_d      = (fill_q == FillMax) ? FillMax : fill_q + 1'b1;
    // fill+1 >= DEPTH is the same as the saturated count reaching DEPTH
    out_valid_d = (fill_d == FillMax);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cap_q       <= ClearW;
      sum_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dly_q[k] <= (k == 0) ? ClearW : '0;
      end
    end else if (in_valid) begin
      cap_q       <= cap_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dly_q[k] <= dly_d[k];
      end
    end
  end

  assign tap       = dly_q[DEPTH-1];
  assign out_valid = out_valid_q;

  always_comb begin
    cct_output = '0;
    unique case (mode)
      2'd0: cct_output = tap ^ cap_q ^ sum_q;
      2'd1: cct_output = tap + cap_q + sum_q;
      2'd2: cct_output = cap_q ^ sum_q;
      2'd3: cct_output = tap;
      default: cct_output = '0;
    endcase
  end

endmodule

// File: tb/tb_xor_add_pipe.sv
// Bench for xor_add_pipe: DEPTH=2 and DEPTH=1 instances share stimulus and are checked
// every cycle, in all four modes, against a history-queue model plus literal expectations.
module tb_xor_add_pipe;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] cct_input = 8'h00;
  logic [1:0] mode = 2'd0;
  logic [7:0] out2, out1;
  logic       ov2, ov1;

  int errors = 0;
  int checks = 0;

  // Accepted-input history since clear, oldest first, seeded with the clear-state line.
  logic [7:0] hist [$];
  logic [7:0] sum_m;
  int         cnt_m;

  always #10 clk = ~clk;

  xor_add_pipe #(.WIDTH(8), .DEPTH(2), .OFFSET(17), .CLEAR_VAL(3)) u_d2 (
    .clk        (clk),
    .clear_n    (clear_n),
    .in_valid   (in_valid),
    .cct_input  (cct_input),
    .mode       (mode),
    .cct_output (out2),
    .out_valid  (ov2)
  );

  xor_add_pipe #(.WIDTH(8), .DEPTH(1), .OFFSET(17), .CLEAR_VAL(3)) u_d1 (
    .clk        (clk),
    .clear_n    (clear_n),
    .in_valid   (in_valid),
    .cct_input  (cct_input),
    .mode       (mode),
    .cct_output (out1),
    .out_valid  (ov1)
  );

  function automatic logic [7:0] combine(input int m, input logic [7:0] t, input logic [7:0] c,
                                         input logic [7:0] s);
    case (m)
      0:       return t ^ c ^ s;
      1:       return t + c + s;
      2:       return c ^ s;
      default: return t;
    endcase
  endfunction

  function automatic logic [7:0] model_out(input int m, input int depth);
    return combine(m, hist[hist.size() - depth], hist[hist.size() - 1], sum_m);
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sweeps every mode on both instances; mode never alters state, so this is safe mid-cycle.
  task automatic check_all();
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      #1;
      cmp($sformatf("d2_out_mode%0d", m), out2, model_out(m, 2));
      cmp($sformatf("d1_out_mode%0d", m), out1, model_out(m, 1));
    end
    cmp("d2_out_valid", {7'd0, ov2}, {7'd0, cnt_m >= 2});
    cmp("d1_out_valid", {7'd0, ov1}, {7'd0, cnt_m >= 1});
  endtask

  task automatic lit(input string name, input logic [1:0] m, input logic [7:0] act_sel,
                     input logic [7:0] exp);
    logic [7:0] act;
    mode = m;
    #1;
    act = (act_sel == 8'd1) ? out1 : out2;
    cmp(name, act, exp);
  endtask

  task automatic step(input logic cn, input logic v, input logic [7:0] x);
    clear_n   = cn;
    in_valid  = v;
    cct_input = x;
    @(posedge clk);
    if (!cn) begin
      hist.delete();
      hist.push_back(8'h00);
      hist.push_back(8'h03);
      sum_m = 8'h00;
      cnt_m = 0;
    end else if (v) begin
      hist.push_back(x);
      if (hist.size() > 4) void'(hist.pop_front());
      sum_m = x + 8'd17;
      if (cnt_m < 4) cnt_m++;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // Clear-only state
    step(1'b0, 1'b0, 8'h00);
    lit("clr_d2_mode0", 2'd0, 8'd2, 8'h03);
    lit("clr_d2_mode3", 2'd3, 8'd2, 8'h00);
    lit("clr_d1_mode0", 2'd0, 8'd1, 8'h00);
    cmp("clr_d2_ov", {7'd0, ov2}, 8'h00);

    // 0x10 then 0x20
    step(1'b1, 1'b1, 8'h10);
    lit("seq1_d2_mode0", 2'd0, 8'd2, 8'h32);
    cmp("seq1_d2_ov", {7'd0, ov2}, 8'h00);
    lit("seq1_d1_mode0", 2'd0, 8'd1, 8'h21);
    cmp("seq1_d1_ov", {7'd0, ov1}, 8'h01);
    step(1'b1, 1'b1, 8'h20);
    lit("seq2_d2_mode0", 2'd0, 8'd2, 8'h01);
    cmp("seq2_d2_ov", {7'd0, ov2}, 8'h01);

    // Stall with junk on the input, then one valid zero
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'hAA);
      lit("stall_d2_mode0", 2'd0, 8'd2, 8'h01);
      cmp("stall_d2_ov", {7'd0, ov2}, 8'h01);
    end
    step(1'b1, 1'b1, 8'h00);
    lit("post_stall_d2_mode0", 2'd0, 8'd2, 8'h31);

    // Steady 0xF0 exercises the adder wrap
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hF0);
    lit("wrap_mode0", 2'd0, 8'd2, 8'h01);
    lit("wrap_mode1", 2'd1, 8'd2, 8'hE1);
    lit("wrap_mode2", 2'd2, 8'd2, 8'hF1);
    lit("wrap_mode3", 2'd3, 8'd2, 8'hF0);

    // Clear wins over a simultaneous valid
    step(1'b0, 1'b1, 8'h55);
    lit("midclr_d2_mode0", 2'd0, 8'd2, 8'h03);
    cmp("midclr_d2_ov", {7'd0, ov2}, 8'h00);
    step(1'b1, 1'b1, 8'h55);
    cmp("midclr_next_d2_ov", {7'd0, ov2}, 8'h00);

    // Randomised traffic with occasional clears and stalls
    for (int i = 0; i < 400; i++) begin
      logic       cn, v;
      logic [7:0] x;
      cn = ($urandom_range(0, 29) != 0);
      v  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       x = 8'hFF;
        1:       x = 8'h00;
        2:       x = 8'hEF;
        default: x = 8'($urandom);
      endcase
      step(cn, v, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
